// File: rtl/probe_led_scanner.sv
// -----------------------------------------------------------------------------
// probe_led_scanner
//
// Captures one 32-bit word from a processor data-read probe and shows it on
// four board LEDs, one nibble at a time, most significant nibble first. Each
// nibble is lit for DWELL_CYCLES cycles and is followed by GAP_CYCLES cycles
// with all LEDs off, so that repeated nibble values remain distinguishable.
// Only the lowest NUM_NIBBLES nibbles are shown. While a word is being shown,
// new probe words are refused (probe_ready low) and the producer holds them.
//
// Parameters
//   DWELL_CYCLES  cycles each nibble is lit                  (>= 1)
//   GAP_CYCLES    blank cycles after each nibble             (>= 0)
//   NUM_NIBBLES   nibbles shown per captured word            (1..8)
//
// Ports
//   clk          single clock, rising-edge active
//   reset        synchronous, active-high reset
//   probe_val    probe word offered for capture
//   probe_valid  probe_val is valid this cycle
//   probe_ready  block accepts a word this cycle (high only in IDLE)
//   led          nibble drive, bit 3 = most significant, 0 when blank/idle
//   nibble_idx   index of the nibble currently shown or pending
//   busy         high whenever a word is being displayed
// -----------------------------------------------------------------------------
module probe_led_scanner #(
  parameter int DWELL_CYCLES = 50000000,
  parameter int GAP_CYCLES   = 12500000,
  parameter int NUM_NIBBLES  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] probe_val,
  input  logic        probe_valid,
  output logic        probe_ready,
  output logic [3:0]  led,
  output logic [2:0]  nibble_idx,
  output logic        busy
);

  // Counter is wide enough for the longer of the two phases, never below 1 bit.
  localparam int MAX_PHASE = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
  localparam int CNT_SPAN  = (MAX_PHASE > 2) ? MAX_PHASE : 2;
  localparam int CNT_W     = $clog2(CNT_SPAN);

  // GAP_LAST is only meaningful when GAP_CYCLES > 0; the guard keeps the
  // constant legal (non-negative) when the blank phase is disabled.
  localparam int GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_LAST_I);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [2:0]       TOP_IDX    = 3'(NUM_NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        word_q,  word_d;
  logic [2:0]         idx_q,   idx_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               nibble_done;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    nibble_done = 1'b0;

    unique case (state_q)
      IDLE: begin
        // probe_ready is 1 here, so probe_valid alone completes the handshake.
        if (probe_valid) begin
          word_d  = probe_val;
          idx_d   = TOP_IDX;
          cnt_d   = '0;
          state_d = SHOW;
        end
      end

      SHOW: begin
        if (cnt_q == DWELL_LAST) begin
          cnt_d = '0;
          // With no blank phase the end of the dwell is the end of the nibble.
          if (GAP_CYCLES == 0) begin
            nibble_done = 1'b1;
          end else begin
            state_d = GAP;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d       = '0;
          nibble_done = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Advance to the next lower nibble, or finish after nibble 0. nibble_idx
    // is left at 0 in IDLE until the next capture reloads it.
    if (nibble_done) begin
      if (idx_q == 3'd0) begin
        state_d = IDLE;
      end else begin
        idx_d   = idx_q - 3'd1;
        state_d = SHOW;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registers only, no combinational input paths.
  // ---------------------------------------------------------------------------
  assign probe_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign nibble_idx  = idx_q;
  assign led         = (state_q == SHOW) ? word_q[{idx_q, 2'b00} +: 4] : 4'h0;

endmodule

// File: tb/tb_probe_led_scanner.sv
// -----------------------------------------------------------------------------
// Bench for probe_led_scanner. Three instances cover the main configuration
// (4/2/8), a configuration without blank phase (4/0/8) and a short one (1/2/2).
// Expected LED/index sequences are generated from the captured word and pushed
// to a queue when a word is offered; they are popped one per display cycle.
// -----------------------------------------------------------------------------
module tb_probe_led_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] probe_val;
  logic        probe_valid;
  int          sel;

  always #5 clk = ~clk;

  logic       valid_a, valid_b, valid_c;
  logic       ready_a, ready_b, ready_c;
  logic       busy_a,  busy_b,  busy_c;
  logic [3:0] led_a,   led_b,   led_c;
  logic [2:0] idx_a,   idx_b,   idx_c;

  assign valid_a = probe_valid && (sel == 0);
  assign valid_b = probe_valid && (sel == 1);
  assign valid_c = probe_valid && (sel == 2);

  probe_led_scanner #(.DWELL_CYCLES(4), .GAP_CYCLES(2), .NUM_NIBBLES(8)) u_main (
    .clk(clk), .reset(reset), .probe_val(probe_val), .probe_valid(valid_a),
    .probe_ready(ready_a), .led(led_a), .nibble_idx(idx_a), .busy(busy_a)
  );

  probe_led_scanner #(.DWELL_CYCLES(4), .GAP_CYCLES(0), .NUM_NIBBLES(8)) u_gap0 (
    .clk(clk), .reset(reset), .probe_val(probe_val), .probe_valid(valid_b),
    .probe_ready(ready_b), .led(led_b), .nibble_idx(idx_b), .busy(busy_b)
  );

  probe_led_scanner #(.DWELL_CYCLES(1), .GAP_CYCLES(2), .NUM_NIBBLES(2)) u_small (
    .clk(clk), .reset(reset), .probe_val(probe_val), .probe_valid(valid_c),
    .probe_ready(ready_c), .led(led_c), .nibble_idx(idx_c), .busy(busy_c)
  );

  // Observed outputs of the instance under test.
  logic       obs_ready, obs_busy;
  logic [3:0] obs_led;
  logic [2:0] obs_idx;

  always_comb begin
    obs_ready = ready_a; obs_busy = busy_a; obs_led = led_a; obs_idx = idx_a;
    case (sel)
      1: begin obs_ready = ready_b; obs_busy = busy_b; obs_led = led_b; obs_idx = idx_b; end
      2: begin obs_ready = ready_c; obs_busy = busy_c; obs_led = led_c; obs_idx = idx_c; end
      default: ;
    endcase
  end

  // Scoreboard of expected per-cycle display values.
  typedef struct {
    logic [3:0] led;
    logic [2:0] idx;
  } exp_t;

  exp_t sb[$];

  // Vector table: instance, word, its timing, expected busy duration.
  typedef struct {
    int          s;
    logic [31:0] word;
    int          dwell;
    int          gap;
    int          nn;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[8];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: nibbles from NUM_NIBBLES-1 down to 0, each lit for dwell cycles
  // then dark for gap cycles.
  task automatic push_display(input logic [31:0] w, input int dwell, input int gap, input int nn);
    exp_t e;
    for (int n = nn - 1; n >= 0; n--) begin
      for (int c = 0; c < dwell; c++) begin
        e.led = w[4*n +: 4];
        e.idx = 3'(n);
        sb.push_back(e);
      end
      for (int c = 0; c < gap; c++) begin
        e.led = 4'h0;
        e.idx = 3'(n);
        sb.push_back(e);
      end
    end
  endtask

  // Offer a word once the DUT is ready; returns at handshake edge + 1.
  task automatic start_vec(input int s, input logic [31:0] w, input int dwell, input int gap,
                           input int nn, input bit hold);
    int budget;
    sel = s;
    #1;
    budget = 0;
    while (!obs_ready && budget < 200) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!obs_ready) check("wait_ready", obs_ready, 1);
    probe_val   = w;
    probe_valid = 1'b1;
    push_display(w, dwell, gap, nn);
    @(posedge clk); #1;
    if (!hold) probe_valid = 1'b0;
  endtask

  task automatic sample_one(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check({name, "_led"},   obs_led,   e.led);
      check({name, "_idx"},   obs_idx,   e.idx);
      check({name, "_ready"}, obs_ready, 0);
      check({name, "_busy"},  obs_busy,  1);
    end
    @(posedge clk); #1;
  endtask

  // Consume lat display cycles, then expect exactly one return to IDLE.
  task automatic drain(input string name, input int lat);
    for (int c = 0; c < lat; c++) sample_one(name);
    check({name, "_ready_back"}, obs_ready, 1);
    check({name, "_busy_done"},  obs_busy,  0);
    check({name, "_led_idle"},   obs_led,   0);
    check({name, "_sb_drained"}, sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 32'h1234ABCD, 4, 2, 8, 48, "main_1234abcd"};
    vecs[1] = '{0, 32'hDEADBEEF, 4, 2, 8, 48, "main_deadbeef"};
    vecs[2] = '{0, 32'h00000000, 4, 2, 8, 48, "main_zero"};
    vecs[3] = '{0, 32'hFEDCBA98, 4, 2, 8, 48, "main_fedcba98"};
    vecs[4] = '{1, 32'h000000F1, 4, 0, 8, 32, "gap0_f1"};
    vecs[5] = '{1, 32'h89ABCDEF, 4, 0, 8, 32, "gap0_89abcdef"};
    vecs[6] = '{2, 32'hFFFFFF9C, 1, 2, 2, 6,  "small_9c"};
    vecs[7] = '{2, 32'h12345635, 1, 2, 2, 6,  "small_35"};

    reset       = 1'b1;
    probe_valid = 1'b0;
    probe_val   = '0;
    sel         = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state on every instance.
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check("rst_ready", obs_ready, 1);
      check("rst_busy",  obs_busy,  0);
      check("rst_led",   obs_led,   0);
      check("rst_idx",   obs_idx,   0);
    end

    // Table-driven displays.
    for (int i = 0; i < 8; i++) begin
      start_vec(vecs[i].s, vecs[i].word, vecs[i].dwell, vecs[i].gap, vecs[i].nn, 1'b0);
      drain(vecs[i].name, vecs[i].lat);
    end

    // Valid held high through a display with a different word on the bus:
    // only the first word is shown, second is taken on the single IDLE cycle.
    start_vec(0, 32'hA1B2C3D4, 4, 2, 8, 1'b1);
    probe_val = 32'h55555555;
    drain("hold_first", 48);
    push_display(32'h55555555, 4, 2, 8);
    @(posedge clk); #1;
    probe_valid = 1'b0;
    drain("hold_second", 48);

    // Reset at cycle 10 of a display aborts it with no resume.
    start_vec(0, 32'h13572468, 4, 2, 8, 1'b0);
    for (int c = 0; c < 10; c++) sample_one("abort_pre");
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    check("abort_led",   obs_led,   0);
    check("abort_busy",  obs_busy,  0);
    check("abort_ready", obs_ready, 1);
    check("abort_idx",   obs_idx,   0);
    repeat (5) @(posedge clk);
    #1;
    check("abort_stay_busy", obs_busy, 0);
    check("abort_stay_led",  obs_led,  0);

    // Reset and valid together: no capture; accepted on the next cycle.
    sel         = 0;
    reset       = 1'b1;
    probe_val   = 32'hC0FFEE12;
    probe_valid = 1'b1;
    @(posedge clk); #1;
    check("rstv_ready", obs_ready, 1);
    check("rstv_busy",  obs_busy,  0);
    check("rstv_led",   obs_led,   0);
    reset = 1'b0;
    push_display(32'hC0FFEE12, 4, 2, 8);
    @(posedge clk); #1;
    probe_valid = 1'b0;
    drain("rstv_capture", 48);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
